htif_exit_reporter: RTL
=======================

Name: htif_exit_reporter

Overview:
- Harness-side producer of the `io_success` / failure status that the top-level test driver consumes.
- Sits on a write-only memory-mapped slave port in the test harness and snoops HTIF "tohost" writes from the DUT.
- Decodes exit and putchar commands. After a drain window it raises a sticky pass or fail indication with the exit code and the cycle count.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 64, request data width; fixed at 64 for the HTIF encoding.
- TOHOST_ADDR, 32'h8000_1000, byte address of the tohost register.
- DRAIN_CYCLES, 16, cycles to wait between accepting an exit and asserting the status outputs; 0 is legal.
- CYC_W, 64, width of the free-running cycle counter.

Ports:
- clock  input  1  single clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  write request valid.
- req_ready  output  1  write request ready.
- req_addr  input  ADDR_W  write address.
- req_data  input  DATA_W  write data.
- console_valid  output  1  one-cycle pulse carrying a console character.
- console_char  output  8  console character.
- io_success  output  1  sticky; program exited with code 0.
- io_failure  output  1  sticky; nonzero exit or malformed exit command.
- exit_code  output  32  captured exit code.
- exit_cycle  output  CYC_W  cycle-counter value at exit acceptance.

Behaviour:
- Reset (reset==0, asynchronous): state=RUN, all outputs 0 except req_ready. req_ready is combinational and equals 1 only in RUN. Counters are cleared.
- Handshake: a write is accepted when req_valid && req_ready.
  - Address != TOHOST_ADDR: accepted and ignored.
  - Data == 0: accepted and ignored.
- Decode of accepted tohost data: dev = data[63:56], cmd = data[55:48], pl = data[47:0].
- Exit: dev==0, cmd==0, pl[0]==1. Capture exit_code = pl[32:1] and exit_cycle = cycle counter. Enter DRAIN.
- Syscall form: dev==0, cmd==0, pl[0]==0. Unsupported; treated as malformed exit with exit_code = 32'hFFFF_FFFF. Enter DRAIN.
- Putchar: dev==1, cmd==1. console_valid=1 and console_char=pl[7:0] on the cycle after acceptance, for exactly one cycle. State stays RUN.
- Any other dev/cmd: accepted and ignored. State stays RUN.
- Cycle counter: increments every cycle after reset and wraps at 2^CYC_W.
- State machine: RUN -> DRAIN -> DONE.
  - DRAIN: down-counter loaded with DRAIN_CYCLES. The transition to DONE occurs when the counter reaches 0.
  - DONE: io_success = (exit_code==0 and not malformed); io_failure = its complement. DONE is held until reset; no other exit.
- Latency: exit accepted at cycle T. Status asserted at T+1+DRAIN_CYCLES. With DRAIN_CYCLES=0, status asserts at T+1.
- req_ready=0 in DRAIN and DONE. Later writes are back-pressured and are never accepted.
- io_success and io_failure are never high together and never deassert before reset.
- Exit code bits above bit 32 of pl are ignored (truncated).
- Reset asserted mid-DRAIN: immediate return to RUN with all outputs cleared. A pending console pulse is dropped.
- A putchar accepted in the same cycle that reset deasserts is not accepted, because req_ready is 0 while reset is low.
- Back-to-back putchar writes on consecutive cycles produce consecutive console pulses; there is no stall.

Decomposition:
- Package htif_pkg holds:
  - HTIF_DEV_SYS=8'h00, HTIF_DEV_CONSOLE=8'h01;
  - HTIF_CMD_EXIT=8'h00, HTIF_CMD_PUTCHAR=8'h01;
  - MALFORMED_CODE=32'hFFFF_FFFF;
  - state enum {RUN, DRAIN, DONE}.
- One sub-module, htif_tohost_decode: combinational classifier producing is_exit, is_malformed, is_putchar, code[31:0], ch[7:0] from 64-bit data.

Test Plan:
- Write 64'h1 to TOHOST_ADDR with DRAIN_CYCLES=16 -> io_success=1 exactly 17 cycles after acceptance, exit_code=0, io_failure=0.
- Write 64'h7 (code 3) -> io_failure=1, exit_code=3, io_success stays 0 until reset.
- Write 64'h0101_0000_0000_0041 then 64'h0101_0000_0000_0042 on consecutive cycles -> console pulses 'A' then 'B' on consecutive cycles; state remains RUN.
- Write 64'h2 (syscall form) -> io_failure=1, exit_code=32'hFFFF_FFFF. Writes to 32'h8000_2000 and writes of value 0 -> no effect.
- After exit, hold req_valid=1 with a putchar -> req_ready=0, no console pulse. Assert reset mid-DRAIN -> outputs cleared, req_ready=1 after release.
- DRAIN_CYCLES=0 with exit code 0 accepted at cycle 100 (counter value) -> io_success=1 at the next cycle, exit_cycle=100.

Source files
------------

// File: rtl/htif_pkg.sv
// Shared HTIF encodings, FSM state type and the pass/fail rule used by the
// tohost exit reporter.
package htif_pkg;

  localparam logic [7:0]  HTIF_DEV_SYS     = 8'h00;
  localparam logic [7:0]  HTIF_DEV_CONSOLE = 8'h01;
  localparam logic [7:0]  HTIF_CMD_EXIT    = 8'h00;
  localparam logic [7:0]  HTIF_CMD_PUTCHAR = 8'h01;
  localparam logic [31:0] MALFORMED_CODE   = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic exit_ok(input logic [31:0] code, input logic malformed);
    return (code == 32'd0) && !malformed;
  endfunction

endpackage

// File: rtl/htif_exit_reporter_if.sv
// Write-only request port carrying tohost stores from the DUT to the harness.
interface htif_exit_reporter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;

  modport master (output req_valid, output req_addr, output req_data, input  req_ready);
  modport slave  (input  req_valid, input  req_addr, input  req_data, output req_ready);
endinterface

// File: rtl/htif_tohost_decode.sv
// Combinational classifier for a 64-bit HTIF tohost word.
module htif_tohost_decode
  import htif_pkg::*;
(
  input  logic [63:0] data,
  output logic        is_exit,
  output logic        is_malformed,
  output logic        is_putchar,
  output logic [31:0] code,
  output logic [7:0]  ch
);

  logic [7:0]  dev;
  logic [7:0]  cmd;
  logic [47:0] pl;
  logic        nonzero;

  assign dev     = data[63:56];
  assign cmd     = data[55:48];
  assign pl      = data[47:0];
  assign nonzero = |data;

  always_comb begin
    is_exit      = 1'b0;
    is_malformed = 1'b0;
    is_putchar   = 1'b0;
    // A zero word is the DUT clearing tohost, not a command.
    if (nonzero && dev == HTIF_DEV_SYS && cmd == HTIF_CMD_EXIT) begin
      is_exit      = pl[0];
      is_malformed = ~pl[0];
    end
    if (dev == HTIF_DEV_CONSOLE && cmd == HTIF_CMD_PUTCHAR) begin
      is_putchar = 1'b1;
    end
    code = pl[0] ? pl[32:1] : MALFORMED_CODE;
    ch   = pl[7:0];
  end

endmodule

// File: rtl/htif_exit_reporter.sv
// Snoops tohost writes, echoes putchar to a console pulse and, after a drain
// window, latches a sticky pass/fail status with exit code and cycle stamp.
module htif_exit_reporter
  import htif_pkg::*;
#(
  parameter int              ADDR_W       = 32,
  parameter int              DATA_W       = 64,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h8000_1000),
  parameter int              DRAIN_CYCLES = 16,
  parameter int              CYC_W        = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  htif_exit_reporter_if.slave    req,
  output logic                   console_valid,
  output logic [7:0]             console_char,
  output logic                   io_success,
  output logic                   io_failure,
  output logic [31:0]            exit_code,
  output logic [CYC_W-1:0]       exit_cycle
);

  localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [CYC_W-1:0]   exit_cycle_q, exit_cycle_d;
  logic [31:0]        exit_code_q, exit_code_d;
  logic               malformed_q, malformed_d;
  logic               success_q, success_d;
  logic               failure_q, failure_d;
  logic               cons_valid_q, cons_valid_d;
  logic [7:0]         cons_char_q, cons_char_d;
  logic               active_q;

  logic               dec_exit, dec_malformed, dec_putchar;
  logic [31:0]        dec_code;
  logic [7:0]         dec_ch;
  logic               accept;
  logic               hit;

  htif_tohost_decode u_decode (
    .data         (req.req_data[DATA_W-1:0]),
    .is_exit      (dec_exit),
    .is_malformed (dec_malformed),
    .is_putchar   (dec_putchar),
    .code         (dec_code),
    .ch           (dec_ch)
  );

  // active_q holds ready low for the cycle in which reset is released.
  assign req.req_ready = active_q && (state_q == RUN);
  assign accept        = req.req_valid && req.req_ready;
  assign hit           = accept && (req.req_addr == TOHOST_ADDR);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cyc_d        = cyc_q + 1'b1;
    exit_cycle_d = exit_cycle_q;
    exit_code_d  = exit_code_q;
    malformed_d  = malformed_q;
    success_d    = success_q;
    failure_d    = failure_q;
    cons_valid_d = 1'b0;
    cons_char_d  = cons_char_q;

    unique case (state_q)
      RUN: begin
        if (hit && dec_putchar) begin
          cons_valid_d = 1'b1;
          cons_char_d  = dec_ch;
        end else if (hit && (dec_exit || dec_malformed)) begin
          exit_code_d  = dec_code;
          malformed_d  = dec_malformed;
          exit_cycle_d = cyc_q;
          if (DRAIN_CYCLES == 0) begin
            state_d   = DONE;
            success_d = exit_ok(dec_code, dec_malformed);
            failure_d = ~exit_ok(dec_code, dec_malformed);
          end else begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYCLES);
          end
        end
      end
      DRAIN: begin
        // Counter reaching zero on this edge lands status exactly DRAIN_CYCLES after entry.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d   = DONE;
          success_d = exit_ok(exit_code_q, malformed_q);
          failure_d = ~exit_ok(exit_code_q, malformed_q);
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      cyc_q        <= '0;
      exit_cycle_q <= '0;
      exit_code_q  <= '0;
      malformed_q  <= 1'b0;
      success_q    <= 1'b0;
      failure_q    <= 1'b0;
      cons_valid_q <= 1'b0;
      cons_char_q  <= '0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cyc_q        <= cyc_d;
      exit_cycle_q <= exit_cycle_d;
      exit_code_q  <= exit_code_d;
      malformed_q  <= malformed_d;
      success_q    <= success_d;
      failure_q    <= failure_d;
      cons_valid_q <= cons_valid_d;
      cons_char_q  <= cons_char_d;
      active_q     <= 1'b1;
    end
  end

  assign console_valid = cons_valid_q;
  assign console_char  = cons_char_q;
  assign io_success    = success_q;
  assign io_failure    = failure_q;
  assign exit_code     = exit_code_q;
  assign exit_cycle    = exit_cycle_q;

endmodule
